// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared size encodings, FSM states and helpers for mem_access_unit
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // Index of the last byte of an access (N-1); the reserved size 11 counts as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: last_idx = 2'd0;
      SZ_HALF: last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mau_extend.sv
// rtl/mau_extend.sv - combinational sign/zero extension of byte and half loads
module mau_extend
  import mau_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sext & i_data[7]}}, i_data[7:0]};
      SZ_HALF: o_data = {{16{i_sext & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - big-endian byte-serial load/store unit over a byte-wide memory
// Optional MAU_ALIGN_CHECK_EN faults misaligned or out-of-range requests.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 64
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] ReadData,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemWData,
  output logic        MemWE,
  output logic        MemRE,
  input  logic [7:0]  MemRData
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_acc;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic [1:0]  r_cnt;
  logic        r_sext;
  logic        r_write;

  logic        w_valid_req;
  logic        w_fault;
  logic        w_last;
  logic [1:0]  w_byte_sel;
  logic [7:0]  w_wbyte;
  logic [31:0] w_acc_next;
  logic [31:0] w_ext;

  assign w_valid_req = Start & (MemRead ^ MemWrite);
  assign w_last      = (r_cnt == last_idx(r_size));
  assign w_byte_sel  = last_idx(r_size) - r_cnt;
  assign w_wbyte     = r_wdata[{w_byte_sel, 3'b000} +: 8];
  assign w_acc_next  = {r_acc[23:0], MemRData};
  assign ReadData    = r_rdata;

`ifdef MAU_ALIGN_CHECK_EN
  logic        r_err;
  logic [32:0] w_end;

  // 33-bit sum so a request near 2^32 cannot wrap past the bound.
  assign w_end   = {1'b0, Address} + {31'b0, last_idx(Size)};
  assign w_fault = ((Size == SZ_HALF) && Address[0])
                 || (Size[1] && (Address[1:0] != 2'b00))
                 || (w_end >= 33'(MEM_BYTES));
  assign Error   = Done & r_err;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_valid_req) begin
      r_err <= w_fault;
    end
  end
`else
  assign w_fault = 1'b0;
  assign Error   = 1'b0;
`endif

  mau_extend u_extend (
    .i_data (w_acc_next),
    .i_size (r_size),
    .i_sext (r_sext),
    .o_data (w_ext)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes are decoded from the state so reset drops them without waiting for a clock.
  always_comb begin
    w_next   = r_state;
    Busy     = 1'b0;
    Done     = 1'b0;
    MemRE    = 1'b0;
    MemWE    = 1'b0;
    MemAddr  = 32'h0;
    MemWData = 8'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid_req) begin
          w_next = w_fault ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        Busy    = 1'b1;
        MemAddr = r_addr + {30'b0, r_cnt};
        MemRE   = ~r_write;
        MemWE   = r_write;
        if (r_write) begin
          MemWData = w_wbyte;
        end
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        Busy   = 1'b1;
        Done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_acc   <= 32'h0;
      r_rdata <= 32'h0;
      r_size  <= SZ_BYTE;
      r_cnt   <= 2'd0;
      r_sext  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid_req) begin
            r_addr  <= Address;
            r_wdata <= WriteData;
            r_size  <= Size;
            r_sext  <= SignExt;
            r_write <= MemWrite;
            r_cnt   <= 2'd0;
            r_acc   <= 32'h0;
          end
        end
        ST_ACCESS: begin
          r_acc <= w_acc_next;
          if (!w_last) begin
            r_cnt <= r_cnt + 2'd1;
          end else if (!r_write) begin
            r_rdata <= w_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a byte-wide memory model
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        SignExt = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        Busy, Done, Error;
  logic [31:0] ReadData, MemAddr;
  logic [7:0]  MemWData, MemRData;
  logic        MemWE, MemRE;

  logic [7:0]  mem [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t        sb[$];

  logic [31:0] tr_addr[$];
  logic [7:0]  tr_data[$];
  logic        tr_we[$];

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.MEM_BYTES(64)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .MemRead(MemRead),
    .MemWrite(MemWrite), .Size(Size), .SignExt(SignExt), .Address(Address),
    .WriteData(WriteData), .Busy(Busy), .Done(Done), .Error(Error),
    .ReadData(ReadData), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData)
  );

  always #5 Clock = ~Clock;

  assign MemRData = mem[MemAddr[5:0]];
  always @(posedge Clock) if (MemWE) mem[MemAddr[5:0]] <= MemWData;

  task automatic issue(input logic wr, input logic rd, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge Clock);
    Start = 1'b1; MemWrite = wr; MemRead = rd; Size = sz; SignExt = sx;
    Address = a; WriteData = d;
    @(posedge Clock);
    #1;
    Start = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  // Issues one request and records every strobed byte until Done (lat = 0 on timeout).
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd, output logic err);
    tr_addr.delete(); tr_data.delete(); tr_we.delete();
    lat = 0; rd = 32'h0; err = 1'b0;
    issue(wr, ~wr, sz, sx, a, d);
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock);
      if (MemWE || MemRE) begin
        tr_addr.push_back(MemAddr); tr_data.push_back(MemWData); tr_we.push_back(MemWE);
      end
      if (Done) begin
        lat = c; rd = ReadData; err = Error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({Busy, Done, Error, MemRE, MemWE} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000", {Busy, Done, Error, MemRE, MemWE});
    end
    checks++;
    if ({MemAddr, MemWData, ReadData} !== 72'h0) begin
      failures++; $display("FAIL reset_buses: got addr=%h wdata=%h rdata=%h expected 0", MemAddr, MemWData, ReadData);
    end
    ResetN = 1'b1;
  endtask

  task automatic test_invalid_type();
    for (int k = 0; k < 2; k++) begin
      issue(k == 0, k == 0, SZ_WORD, 1'b0, 32'd8, 32'h0);
      @(negedge Clock);
      checks++;
      if ({Busy, MemRE, MemWE} !== 3'b000) begin
        failures++; $display("FAIL invalid_type_%0d: got busy/re/we=%b expected 000", k, {Busy, MemRE, MemWE});
      end
    end
  endtask

  task automatic test_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] held);
    int lat; logic [31:0] rd; logic err; exp_t e; int n;
    n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    sb.push_back('{rdata: held, err: 1'b0, lat: n + 1});
    run_op(1'b1, sz, 1'b0, a, d, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL store_latency: got %0d expected %0d", lat, e.lat); end
    checks++;
    if (rd !== e.rdata || err !== e.err) begin
      failures++; $display("FAIL store_rdata_err: got %h/%b expected %h/%b", rd, err, e.rdata, e.err);
    end
    checks++;
    if (tr_addr.size() != n) begin
      failures++; $display("FAIL store_strobe_count: got %0d expected %0d", tr_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] sh;
        sh = d >> (8 * (n - 1 - i));
        checks++;
        if (tr_addr[i] !== a + i || tr_data[i] !== sh[7:0] || tr_we[i] !== 1'b1) begin
          failures++;
          $display("FAIL store_byte_%0d: got addr=%h data=%h we=%b expected addr=%h data=%h we=1",
                   i, tr_addr[i], tr_data[i], tr_we[i], a + i, sh[7:0]);
        end
      end
    end
  endtask

  task automatic test_loads();
    logic [1:0]  t_sz  [6] = '{SZ_WORD, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_WORD};
    logic        t_sx  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_a   [6] = '{32'd8, 32'd9, 32'd9, 32'd10, 32'd60, 32'd8};
    logic [31:0] t_exp [6] = '{32'hDEADBEEF, 32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF,
                               32'h0000A1B2, 32'h0000DEAD};
    mem[60] = 8'hA1; mem[61] = 8'hB2; mem[62] = 8'hC3; mem[63] = 8'hD4;
    for (int k = 0; k < 6; k++) begin
      int lat; logic [31:0] rd; logic err; exp_t e; int n; logic [1:0] sz;
      sz = t_sz[k];
      // last entry is lhu 8 reusing the SZ_WORD slot's address with a half size
      if (k == 5) sz = SZ_HALF;
      n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
      sb.push_back('{rdata: t_exp[k], err: 1'b0, lat: n + 1});
      run_op(1'b0, sz, (k == 5) ? 1'b0 : t_sx[k], t_a[k], 32'h0, lat, rd, err);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || err !== e.err || lat !== e.lat) begin
        failures++;
        $display("FAIL load_%0d: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                 k, rd, err, lat, e.rdata, e.err, e.lat);
      end
      checks++;
      if (tr_addr.size() != n || tr_we.sum() != 0 || tr_addr[0] !== t_a[k] || tr_addr[n-1] !== t_a[k] + n - 1) begin
        failures++; $display("FAIL load_strobes_%0d: got %0d reads first=%h expected %0d first=%h",
                             k, tr_addr.size(), (tr_addr.size() > 0) ? tr_addr[0] : 32'hx, n, t_a[k]);
      end
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err; exp_t e;
    mem[6] = 8'h12; mem[7] = 8'h34;
`ifdef MAU_ALIGN_CHECK_EN
    sb.push_back('{rdata: 32'h0000DEAD, err: 1'b1, lat: 1});
`else
    sb.push_back('{rdata: 32'h1234DEAD, err: 1'b0, lat: 5});
`endif
    run_op(1'b0, SZ_WORD, 1'b0, 32'd6, 32'h0, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || err !== e.err || lat !== e.lat) begin
      failures++; $display("FAIL lw_misaligned: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                           rd, err, lat, e.rdata, e.err, e.lat);
    end
    checks++;
    if (tr_addr.size() != ((e.err) ? 0 : 4)) begin
      failures++; $display("FAIL lw_misaligned_strobes: got %0d expected %0d", tr_addr.size(), e.err ? 0 : 4);
    end
`ifdef MAU_ALIGN_CHECK_EN
    run_op(1'b0, SZ_WORD, 1'b0, 32'd64, 32'h0, lat, rd, err);
    checks++;
    if (err !== 1'b1 || lat !== 1 || tr_addr.size() != 0 || rd !== 32'h0000DEAD) begin
      failures++; $display("FAIL lw_out_of_range: got err=%b lat=%0d strobes=%0d rdata=%h expected 1/1/0/0000dead",
                           err, lat, tr_addr.size(), rd);
    end
`endif
  endtask

  task automatic test_reset_abort();
    for (int i = 20; i < 24; i++) mem[i] = 8'h00;
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd20, 32'h11223344);
    repeat (3) @(negedge Clock);
    checks++;
    if (MemWE !== 1'b1 || MemAddr !== 32'd22) begin
      failures++; $display("FAIL abort_third_byte: got we=%b addr=%h expected we=1 addr=00000016", MemWE, MemAddr);
    end
    ResetN = 1'b0;
    #1;
    checks++;
    if (MemWE !== 1'b0 || Busy !== 1'b0) begin
      failures++; $display("FAIL abort_async: got we=%b busy=%b expected 0/0", MemWE, Busy);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    checks++;
    if ({mem[20], mem[21], mem[22], mem[23]} !== 32'h11220000) begin
      failures++; $display("FAIL abort_memory: got %h expected 11220000", {mem[20], mem[21], mem[22], mem[23]});
    end
  endtask

  task automatic test_busy_ignore();
    int dones; logic [31:0] got; exp_t e;
    dones = 0; got = 32'h0;
    mem[30] = 8'h00;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 5});
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'd8, 32'h0);
    @(negedge Clock);
    Start = 1'b1; MemWrite = 1'b1; Size = SZ_BYTE; Address = 32'd30; WriteData = 32'hAA;
    @(posedge Clock);
    #1;
    Start = 1'b0; MemWrite = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (Done) begin dones++; got = ReadData; end
    end
    e = sb.pop_front();
    checks++;
    if (dones !== 1 || got !== e.rdata) begin
      failures++; $display("FAIL busy_ignore: got dones=%0d rdata=%h expected 1/%h", dones, got, e.rdata);
    end
    checks++;
    if (mem[30] !== 8'h00 || Busy !== 1'b0) begin
      failures++; $display("FAIL busy_ignore_mem: got mem30=%h busy=%b expected 00/0", mem[30], Busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_invalid_type();
    test_store(SZ_WORD, 32'd8, 32'hDEADBEEF, 32'h0);
    test_loads();
    test_store(SZ_HALF, 32'd12, 32'h1234ABCD, 32'h0000DEAD);
    test_misaligned();
    test_reset_abort();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
